mul_rr_scheduler: RTL and testbench

- Shares one 8-bit multiplier datapath (m, n -> 16-bit mul) among NUM_REQ requesters using round-robin arbitration.
- Accepts one operand pair at a time through per-requester valid/ready.
- Drives the multiplier operands, waits a fixed latency, then captures the product.
- Returns the product with the requester ID on a single valid/ready response channel.
- Sits between requesting agents and the multiplier.

---
 rtl/mul_rr_scheduler_pkg.sv | 24 ++
 rtl/mul_rr_scheduler_if.sv | 35 +++
 rtl/mul_rr_scheduler_rr_pick.sv | 30 +++
 rtl/mul_rr_scheduler.sv | 131 +++++++++++++
 tb/tb_mul_rr_scheduler.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
package mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_MUL_LAT = 1;

    // Folds an index that may have stepped one lap past n back into 0..n-1.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

    // Requester index following idx, wrapping modulo n.
    function automatic int next_ptr(input int idx, input int n);
        return wrap_idx(idx + 1, n);
    endfunction

endpackage

// File: rtl/mul_rr_scheduler_if.sv
// Request, multiplier and response signals of the scheduler in one bundle.
interface mul_rr_scheduler_if
    import mul_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_m;
    logic [NUM_REQ*WIDTH-1:0] req_n;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         mul_m;
    logic [WIDTH-1:0]         mul_n;
    logic [2*WIDTH-1:0]       mul_in;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [2*WIDTH-1:0]       resp_data;
    logic [IDW-1:0]           resp_id;
    logic                     busy;

    // Environment side: requesters, multiplier and response consumer.
    modport master (
        output req_valid, req_m, req_n, mul_in, resp_ready,
        input  req_ready, mul_m, mul_n, resp_valid, resp_data, resp_id, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_m, req_n, mul_in, resp_ready,
        output req_ready, mul_m, mul_n, resp_valid, resp_data, resp_id, busy
    );

endinterface

// File: rtl/mul_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above the pointer.
module rr_pick
    import mul_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDW-1:0]     rr_ptr_i,
    output logic               grant_valid_o,
    output logic [IDW-1:0]     grant_idx_o
);

    int cand;

    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand          = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = wrap_idx(int'(rr_ptr_i) + k, NUM_REQ);
            if (req_valid_i[IDW'(cand)]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one multiplier among NUM_REQ requesters with round-robin arbitration,
// returning each product tagged with the id of the requester that supplied it.
module mul_rr_scheduler
    import mul_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input logic               clk,
    input logic               rst_n,
    mul_rr_scheduler_if.slave bus
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = 4;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rrPtr_q, rrPtr_d;
    logic [IDW-1:0]       respId_q, respId_d;
    logic [WIDTH-1:0]     mulM_q, mulM_d;
    logic [WIDTH-1:0]     mulN_q, mulN_d;
    logic                 respValid_q, respValid_d;
    logic [2*WIDTH-1:0]   respData_q, respData_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;

    logic                 grantValid;
    logic [IDW-1:0]       grantIdx;
    logic [NUM_REQ-1:0]   reqReady;
    logic [WIDTH-1:0]     selM;
    logic [WIDTH-1:0]     selN;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid_i   (bus.req_valid),
        .rr_ptr_i      (rrPtr_q),
        .grant_valid_o (grantValid),
        .grant_idx_o   (grantIdx)
    );

    // Select the winning requester's operand pair out of the packed buses.
    always_comb begin
        selM = '0;
        selN = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantIdx == IDW'(i)) begin
                selM = bus.req_m[i*WIDTH +: WIDTH];
                selN = bus.req_n[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic. mul_in becomes valid MUL_LAT edges after the operands are
    // registered, so the counter starts at MUL_LAT and the capture happens on the
    // edge after that, giving exactly MUL_LAT+1 WAIT cycles.
    always_comb begin
        state_d     = state_q;
        rrPtr_d     = rrPtr_q;
        respId_d    = respId_q;
        mulM_d      = mulM_q;
        mulN_d      = mulN_q;
        respValid_d = respValid_q;
        respData_d  = respData_q;
        cnt_d       = cnt_q;
        reqReady    = '0;
        unique case (state_q)
            IDLE: begin
                if (grantValid) begin
                    reqReady[grantIdx] = 1'b1;
                    mulM_d   = selM;
                    mulN_d   = selN;
                    respId_d = grantIdx;
                    rrPtr_d  = IDW'(next_ptr(int'(grantIdx), NUM_REQ));
                    cnt_d    = CNTW'(MUL_LAT);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    respData_d  = bus.mul_in;
                    respValid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (respValid_q && bus.resp_ready) begin
                    respValid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rrPtr_q     <= '0;
            respId_q    <= '0;
            mulM_q      <= '0;
            mulN_q      <= '0;
            respValid_q <= 1'b0;
            respData_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rrPtr_q     <= rrPtr_d;
            respId_q    <= respId_d;
            mulM_q      <= mulM_d;
            mulN_q      <= mulN_d;
            respValid_q <= respValid_d;
            respData_q  <= respData_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req_ready  = reqReady;
    assign bus.mul_m      = mulM_q;
    assign bus.mul_n      = mulN_q;
    assign bus.resp_valid = respValid_q;
    assign bus.resp_data  = respData_q;
    assign bus.resp_id    = respId_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Drives two schedulers (MUL_LAT=1 and MUL_LAT=4) from shared requesters and
// compares every cycle against a transaction-timeline reference model.
module tb_mul_rr_scheduler;
    import mul_sched_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int LAT_A = 1;
    localparam int LAT_B = 4;
    localparam int IDW   = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   reqValid;
    logic [N*W-1:0] reqM;
    logic [N*W-1:0] reqN;
    logic           respReady;
    logic [W-1:0]   opM [N];
    logic [W-1:0]   opN [N];
    logic [W-1:0]   stageM [N];
    logic [W-1:0]   stageN [N];
    logic [2*W-1:0] pipeA [LAT_A];
    logic [2*W-1:0] pipeB [LAT_B];
    logic [N-1:0]   rv;

    int             lat [2];
    bit             inFlight [2];
    bit             freshReset [2];
    int             respAt [2];
    int             ptr [2];
    int             expId [2];
    logic [2*W-1:0] expData [2];
    logic [W-1:0]   expMulM [2];
    logic [W-1:0]   expMulN [2];
    int             cyc;
    int             nChecks;
    int             nFails;

    always #5 clk = ~clk;

    // Pack per-requester operands into the flat request buses.
    always_comb begin
        reqM = '0;
        reqN = '0;
        for (int i = 0; i < N; i++) begin
            reqM[i*W +: W] = opM[i];
            reqN[i*W +: W] = opN[i];
        end
    end

    mul_rr_scheduler_if #(.NUM_REQ(N), .WIDTH(W)) ifA ();
    mul_rr_scheduler_if #(.NUM_REQ(N), .WIDTH(W)) ifB ();

    assign ifA.req_valid  = reqValid;
    assign ifA.req_m      = reqM;
    assign ifA.req_n      = reqN;
    assign ifA.resp_ready = respReady;
    assign ifA.mul_in     = pipeA[LAT_A-1];
    assign ifB.req_valid  = reqValid;
    assign ifB.req_m      = reqM;
    assign ifB.req_n      = reqN;
    assign ifB.resp_ready = respReady;
    assign ifB.mul_in     = pipeB[LAT_B-1];

    // Multiplier models: product appears MUL_LAT edges after the operands settle.
    always @(posedge clk) begin
        pipeA[0] <= 16'(ifA.mul_m) * 16'(ifA.mul_n);
        for (int k = 1; k < LAT_A; k++) pipeA[k] <= pipeA[k-1];
        pipeB[0] <= 16'(ifB.mul_m) * 16'(ifB.mul_n);
        for (int k = 1; k < LAT_B; k++) pipeB[k] <= pipeB[k-1];
    end

    mul_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(LAT_A)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA.slave)
    );

    mul_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(LAT_B)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB.slave)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            inFlight[d]   = 1'b0;
            freshReset[d] = 1'b1;
            respAt[d]     = 0;
            ptr[d]        = 0;
            expId[d]      = 0;
            expData[d]    = '0;
            expMulM[d]    = '0;
            expMulN[d]    = '0;
        end
    endtask

    // One clock cycle: apply inputs at negedge, compare both DUTs, advance model.
    task automatic applyStimulus(input logic rstVal, input logic [N-1:0] v, input logic rdy);
        logic [N-1:0]   expReady, obsReady;
        logic           expRv, obsRv, obsBusy;
        logic [W-1:0]   obsM, obsN;
        logic [2*W-1:0] obsData;
        logic [IDW-1:0] obsId;
        int             w;
        string          dn;
        @(negedge clk);
        rst_n     = rstVal;
        reqValid  = v;
        respReady = rdy;
        for (int i = 0; i < N; i++) begin
            opM[i] = stageM[i];
            opN[i] = stageN[i];
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            dn = (d == 0) ? "A" : "B";
            if (d == 0) begin
                obsReady = ifA.req_ready; obsRv = ifA.resp_valid; obsBusy = ifA.busy;
                obsM = ifA.mul_m; obsN = ifA.mul_n; obsData = ifA.resp_data; obsId = ifA.resp_id;
            end else begin
                obsReady = ifB.req_ready; obsRv = ifB.resp_valid; obsBusy = ifB.busy;
                obsM = ifB.mul_m; obsN = ifB.mul_n; obsData = ifB.resp_data; obsId = ifB.resp_id;
            end
            expRv    = inFlight[d] && (cyc >= respAt[d]);
            expReady = '0;
            w        = -1;
            if (!inFlight[d]) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (((v >> ((ptr[d] + k) % N)) & 1) != 0) w = (ptr[d] + k) % N;
                end
            end
            if (w >= 0) expReady = N'(1) << w;
            checkOutput({dn, "_req_ready"},  32'(obsReady), 32'(expReady));
            checkOutput({dn, "_resp_valid"}, 32'(obsRv),    32'(expRv));
            checkOutput({dn, "_busy"},       32'(obsBusy),  32'(inFlight[d]));
            checkOutput({dn, "_mul_m"},      32'(obsM),     32'(expMulM[d]));
            checkOutput({dn, "_mul_n"},      32'(obsN),     32'(expMulN[d]));
            if (expRv || freshReset[d]) begin
                checkOutput({dn, "_resp_data"}, 32'(obsData), 32'(expData[d]));
                checkOutput({dn, "_resp_id"},   32'(obsId),    32'(expId[d]));
            end
            if (!rstVal) begin
                inFlight[d]   = 1'b0;
                freshReset[d] = 1'b1;
                ptr[d]        = 0;
                expMulM[d]    = '0;
                expMulN[d]    = '0;
                expData[d]    = '0;
                expId[d]      = 0;
            end else if (w >= 0) begin
                inFlight[d]   = 1'b1;
                freshReset[d] = 1'b0;
                respAt[d]     = cyc + lat[d] + 2;
                ptr[d]        = (w + 1) % N;
                expId[d]      = w;
                expMulM[d]    = opM[w];
                expMulN[d]    = opN[w];
                expData[d]    = 16'(opM[w]) * 16'(opN[w]);
            end else if (expRv && rdy) begin
                inFlight[d] = 1'b0;
            end
        end
        cyc++;
    endtask

    initial begin
        rst_n     = 1'b0;
        reqValid  = '0;
        respReady = 1'b1;
        rv        = '0;
        lat[0]    = LAT_A;
        lat[1]    = LAT_B;
        cyc       = 0;
        nChecks   = 0;
        nFails    = 0;
        for (int i = 0; i < N; i++) begin
            opM[i] = '0; opN[i] = '0; stageM[i] = '0; stageN[i] = '0;
        end
        modelReset();
        repeat (5) @(negedge clk);

        $display("[TB] reset state");
        applyStimulus(1'b0, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b1);

        $display("[TB] single request on 2: 12*13");
        stageM[2] = 8'd12; stageN[2] = 8'd13;
        applyStimulus(1'b1, 4'b0100, 1'b1);
        repeat (9) applyStimulus(1'b1, 4'b0000, 1'b1);

        $display("[TB] reset during WAIT drops the transaction");
        stageM[0] = 8'd200; stageN[0] = 8'd3;
        applyStimulus(1'b1, 4'b0001, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        repeat (8) applyStimulus(1'b1, 4'b0000, 1'b1);

        $display("[TB] all four continuously, then back-pressure");
        stageM[0] = 8'hFF; stageN[0] = 8'hFF;
        stageM[1] = 8'd3;  stageN[1] = 8'd5;
        stageM[2] = 8'h10; stageN[2] = 8'h20;
        stageM[3] = 8'hAB; stageN[3] = 8'h02;
        repeat (20) applyStimulus(1'b1, 4'b1111, 1'b1);
        for (int c = 0; c < 32; c++) applyStimulus(1'b1, 4'b1111, (c % 8) >= 5);
        repeat (10) applyStimulus(1'b1, 4'b0000, 1'b1);

        $display("[TB] wrap-around from pointer 3");
        applyStimulus(1'b0, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0100, 1'b1);
        repeat (9) applyStimulus(1'b1, 4'b0000, 1'b1);
        repeat (14) applyStimulus(1'b1, 4'b1010, 1'b1);
        repeat (9) applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b1000, 1'b1);
        repeat (9) applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0001, 1'b1);
        repeat (9) applyStimulus(1'b1, 4'b0000, 1'b1);

        $display("[TB] 7*9 through both latencies");
        stageM[1] = 8'd7; stageN[1] = 8'd9;
        applyStimulus(1'b1, 4'b0010, 1'b1);
        repeat (9) applyStimulus(1'b1, 4'b0000, 1'b1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (((rv >> i) & 1) != 0) begin
                    if ($urandom_range(0, 9) == 0) rv = rv & ~(N'(1) << i);
                end else if ($urandom_range(0, 2) == 0) begin
                    rv        = rv | (N'(1) << i);
                    stageM[i] = 8'($urandom);
                    stageN[i] = 8'($urandom);
                end
            end
            applyStimulus($urandom_range(0, 149) != 0, rv, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
